mult_job_issuer: RTL

// - Host side of the sequential 8x8 multiplier start/done protocol; drives the multiplier controller.
// - Accepts operand pairs on a valid/ready request port and holds them stable for the datapath.
// - Pulses start, waits for done, returns the 16-bit product on a valid/ready response port.
// - Watchdog detects a hung or errored controller, re-issues the job and reports failure.

---
 rtl/mult_pkg.sv | 30 +++
 rtl/mult_job_issuer_if.sv | 39 +++
 rtl/mult_watchdog.sv | 49 ++++
 rtl/mult_job_issuer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared encodings for the sequential 8x8 multiplier job issuer.
//  - MS_* : controller state_out encodings as seen on mult_state.
//  - issuer_state_e : issuer FSM states S_IDLE/S_START/S_WAIT/S_RESP.
//  - start_allowed() : controller states in which a start pulse may be sent.
// -----------------------------------------------------------------------------
package mult_pkg;

   localparam logic [2:0] MS_IDLE      = 3'b000;
   localparam logic [2:0] MS_INIT      = 3'b001;
   localparam logic [2:0] MS_CALC      = 3'b010;
   localparam logic [2:0] MS_SHIFT     = 3'b011;
   localparam logic [2:0] MS_CALC_DONE = 3'b100;
   localparam logic [2:0] MS_ERR       = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } issuer_state_e;

   // The controller only listens for start in IDLE; ERR is also accepted so
   // that a retry can kick a controller that has just faulted.
   function automatic logic start_allowed(input logic [2:0] ms);
      return (ms == MS_IDLE) || (ms == MS_ERR);
   endfunction

endpackage

// File: rtl/mult_job_issuer_if.sv
// -----------------------------------------------------------------------------
// mult_job_issuer_if
// Bundles the issuer's request port, response port and multiplier controller
// link.
//  - slave  : the issuer's view (accepts requests, drives the controller,
//             produces responses).
//  - master : the host/controller side view.
// Signals: req_valid/req_ready/req_a/req_b, op_a/op_b/start, done/mult_state/
//          product, rsp_valid/rsp_ready/rsp_product/rsp_err, busy.
// -----------------------------------------------------------------------------
interface mult_job_issuer_if;

   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_a;
   logic [7:0]  req_b;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic        start;
   logic        done;
   logic [2:0]  mult_state;
   logic [15:0] product;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_product;
   logic        rsp_err;
   logic        busy;

   modport slave (
      input  req_valid, req_a, req_b, done, mult_state, product, rsp_ready,
      output req_ready, op_a, op_b, start, rsp_valid, rsp_product, rsp_err, busy
   );

   modport master (
      output req_valid, req_a, req_b, done, mult_state, product, rsp_ready,
      input  req_ready, op_a, op_b, start, rsp_valid, rsp_product, rsp_err, busy
   );

endinterface

// File: rtl/mult_watchdog.sv
// -----------------------------------------------------------------------------
// mult_watchdog
// Saturating cycle counter guarding the wait for controller done.
// Ports:
//  clk, reset_a : clock, synchronous active-high reset.
//  clear_i      : zero the count (start pulse cycle).
//  en_i         : count this cycle (waiting for done).
//  reached_o    : this enabled cycle brings the count to TIMEOUT_CYC.
// -----------------------------------------------------------------------------
module mult_watchdog
   import mult_pkg::*;
#(
   parameter int TIMEOUT_CYC = 8
) (
   input  logic clk,
   input  logic reset_a,
   input  logic clear_i,
   input  logic en_i,
   output logic reached_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Flag the cycle whose increment reaches the limit, so the abort decision
   // is taken in the TIMEOUT_CYC-th waiting cycle rather than one later.
   assign reached_o = en_i && !clear_i && (cnt_q >= LIMIT_M1);

   always_ff @(posedge clk) begin
      if (reset_a) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mult_job_issuer.sv
// -----------------------------------------------------------------------------
// mult_job_issuer
// Host side of the sequential 8x8 multiplier start/done protocol. Takes an
// operand pair on the request port, holds it on op_a/op_b, pulses start,
// waits for done and returns the 16-bit product on the response port. A
// watchdog aborts a hung or errored job, re-issues it up to MAX_RETRY times
// and then reports rsp_err with a zero product.
// Parameters: TIMEOUT_CYC (>= 5) cycles from start to abort; MAX_RETRY.
// Ports:
//  clk, reset_a : clock, synchronous active-high reset.
//  bus (slave)  : request, response and controller link, see
//                 mult_job_issuer_if.
// -----------------------------------------------------------------------------
module mult_job_issuer
   import mult_pkg::*;
#(
   parameter int TIMEOUT_CYC = 8,
   parameter int MAX_RETRY   = 1
) (
   input  logic             clk,
   input  logic             reset_a,
   mult_job_issuer_if.slave bus
);

   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   issuer_state_e      state_q, state_d;
   logic [7:0]         op_a_q, op_a_d;
   logic [7:0]         op_b_q, op_b_d;
   logic [15:0]        rsp_product_q, rsp_product_d;
   logic               rsp_err_q, rsp_err_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [RETRY_W-1:0] retry_q, retry_d;

   logic start_s;
   logic wd_clear;
   logic wd_en;
   logic wd_reached;

   mult_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wd (
      .clk       (clk),
      .reset_a   (reset_a),
      .clear_i   (wd_clear),
      .en_i      (wd_en),
      .reached_o (wd_reached)
   );

   always_comb begin
      state_d       = state_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      rsp_product_d = rsp_product_q;
      rsp_err_d     = rsp_err_q;
      rsp_valid_d   = rsp_valid_q;
      retry_d       = retry_q;
      start_s       = 1'b0;
      wd_clear      = 1'b0;
      wd_en         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_a_d  = bus.req_a;
               op_b_d  = bus.req_b;
               state_d = S_START;
            end
         end

         S_START: begin
            // Hold the pulse off while the controller is mid-operation.
            if (start_allowed(bus.mult_state)) begin
               start_s  = 1'b1;
               wd_clear = 1'b1;
               state_d  = S_WAIT;
            end
         end

         S_WAIT: begin
            wd_en = 1'b1;
            // done takes priority over a coincident timeout or ERR.
            if (bus.done) begin
               rsp_product_d = bus.product;
               rsp_err_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = S_RESP;
            end else if (wd_reached || (bus.mult_state == MS_ERR)) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = S_START;
               end else begin
                  rsp_product_d = '0;
                  rsp_err_d     = 1'b1;
                  rsp_valid_d   = 1'b1;
                  state_d       = S_RESP;
               end
            end
         end

         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               retry_d     = '0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_a) begin
         state_q       <= S_IDLE;
         op_a_q        <= '0;
         op_b_q        <= '0;
         rsp_product_q <= '0;
         rsp_err_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         retry_q       <= '0;
      end else begin
         state_q       <= state_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         rsp_product_q <= rsp_product_d;
         rsp_err_q     <= rsp_err_d;
         rsp_valid_q   <= rsp_valid_d;
         retry_q       <= retry_d;
      end
   end

   assign bus.req_ready   = (state_q == S_IDLE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.start       = start_s;
   assign bus.op_a        = op_a_q;
   assign bus.op_b        = op_b_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_product = rsp_product_q;
   assign bus.rsp_err     = rsp_err_q;

endmodule
